// File: rtl/trig_scheduler.sv
// trig_scheduler: round-robin trigger arbiter with readout handshake, busy timeout, holdoff and counters
module trig_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int CNT_WIDTH = 16,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       global_en,
  input  logic [NUM_SRC-1:0]         src_trig,
  input  logic [NUM_SRC-1:0]         src_en,
  input  logic [HOLDOFF_WIDTH-1:0]   holdoff_cycles,
  input  logic                       readout_busy,
  output logic                       readout_start,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic [CNT_WIDTH-1:0]       accepted_count,
  output logic [CNT_WIDTH-1:0]       dropped_count,
  output logic                       err_no_busy,
  output logic                       sched_busy
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, BUSY, HOLDOFF} state_t;
  state_t state, state_nx;
  logic [NUM_SRC-1:0] prev, pending, pending_nx, edges, clr, drops;
  logic [IW-1:0] ptr, gnt, idx;
  logic found, grant, timeout;
  logic [TW-1:0] wait_cnt;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt;
  logic [CNT_WIDTH:0] drop_sum;
  assign edges = src_trig & ~prev & src_en & {NUM_SRC{global_en}};
  assign grant = state == IDLE && global_en && found;
  assign clr = grant ? NUM_SRC'(1) << gnt : '0;
  assign drops = edges & pending & ~clr;
  assign pending_nx = (pending & ~clr & src_en & {NUM_SRC{global_en}}) | edges;
  assign drop_sum = {1'b0, dropped_count} + (CNT_WIDTH + 1)'($countones(drops));
  assign timeout = wait_cnt == TW'(BUSY_TIMEOUT - 1);
  assign sched_busy = state != IDLE;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_SRC);
      if (pending[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = grant ? WAIT_BUSY : IDLE;
      WAIT_BUSY: state_nx = readout_busy ? BUSY : timeout ? HOLDOFF : WAIT_BUSY;
      BUSY:      state_nx = readout_busy ? BUSY : holdoff_cycles == '0 ? IDLE : HOLDOFF;
      HOLDOFF:   state_nx = hold_cnt <= HOLDOFF_WIDTH'(1) ? IDLE : HOLDOFF;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      prev           <= src_trig;
      pending        <= '0;
      ptr            <= '0;
      grant_id       <= '0;
      readout_start  <= 1'b0;
      accepted_count <= '0;
      dropped_count  <= '0;
      err_no_busy    <= 1'b0;
      wait_cnt       <= '0;
      hold_cnt       <= '0;
    end else begin
      state         <= state_nx;
      prev          <= src_trig;
      pending       <= pending_nx;
      readout_start <= grant;
      if (grant) begin
        grant_id       <= gnt;
        ptr            <= gnt == IW'(NUM_SRC - 1) ? '0 : gnt + IW'(1);
        accepted_count <= accepted_count + CNT_WIDTH'(1);
      end
      dropped_count <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
      wait_cnt      <= state == WAIT_BUSY ? wait_cnt + TW'(1) : '0;
      err_no_busy   <= err_no_busy | (state == WAIT_BUSY && !readout_busy && timeout);
      hold_cnt      <= (state_nx == HOLDOFF && state != HOLDOFF) ? holdoff_cycles :
                       (state == HOLDOFF && hold_cnt != '0) ? hold_cnt - HOLDOFF_WIDTH'(1) : hold_cnt;
    end
  end
endmodule

// File: tb/tb_trig_scheduler.sv
// tb_trig_scheduler: directed vector table plus hand-written multi-cycle sequences
module tb_trig_scheduler;
  localparam int NS = 4;
  localparam int CW = 4;
  localparam int HW = 16;
  localparam int BT = 8;
  logic clk = 1'b0;
  logic rst, global_en, readout_busy, readout_start, err_no_busy, sched_busy;
  logic [NS-1:0] src_trig, src_en;
  logic [HW-1:0] holdoff_cycles;
  logic [1:0] grant_id;
  logic [CW-1:0] accepted_count, dropped_count;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  trig_scheduler #(.NUM_SRC(NS), .CNT_WIDTH(CW), .HOLDOFF_WIDTH(HW), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .global_en(global_en), .src_trig(src_trig), .src_en(src_en),
    .holdoff_cycles(holdoff_cycles), .readout_busy(readout_busy), .readout_start(readout_start),
    .grant_id(grant_id), .accepted_count(accepted_count), .dropped_count(dropped_count),
    .err_no_busy(err_no_busy), .sched_busy(sched_busy)
  );
  typedef struct {
    int r, ge, trig, busy;
    int st, gid, acc, drop, err, sb;
  } vec_t;
  vec_t vecs[$];
  function automatic void add(int r, int ge, int trig, int busy, int st, int gid, int acc, int drop, int err, int sb);
    vec_t t;
    t = '{r: r, ge: ge, trig: trig, busy: busy, st: st, gid: gid, acc: acc, drop: drop, err: err, sb: sb};
    vecs.push_back(t);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic init_seq();
    src_trig = '0;
    src_en = '1;
    global_en = 1'b1;
    readout_busy = 1'b0;
    holdoff_cycles = '0;
    do_reset();
  endtask
  task automatic wait_start(input int max, output int n);
    n = 0;
    while (!readout_start && n < max) begin
      step();
      n++;
    end
  endtask
  task automatic count_starts(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (readout_start) c++;
    end
  endtask
  initial begin
    int n, c, first, gap;
    int exp_gid[3];
    add(1, 1, 'b0000, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 'b0100, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 'b0100, 0, 1, 2, 1, 0, 0, 1);
    add(0, 1, 'b0100, 0, 0, 2, 1, 0, 0, 1);
    add(0, 1, 'b0100, 1, 0, 2, 1, 0, 0, 1);
    add(0, 1, 'b0110, 1, 0, 2, 1, 0, 0, 1);
    add(0, 1, 'b0110, 0, 0, 2, 1, 0, 0, 1);
    add(0, 1, 'b0100, 0, 0, 2, 1, 0, 0, 1);
    add(0, 1, 'b0110, 0, 0, 2, 1, 1, 0, 0);
    add(0, 1, 'b0110, 0, 1, 1, 2, 1, 0, 1);
    for (int i = 0; i < 7; i++) add(0, 1, 'b0110, 0, 0, 1, 2, 1, 0, 1);
    add(0, 1, 'b0110, 0, 0, 1, 2, 1, 1, 1);
    add(0, 1, 'b0110, 0, 0, 1, 2, 1, 1, 1);
    add(0, 1, 'b0110, 0, 0, 1, 2, 1, 1, 0);
    add(0, 1, 'b0110, 0, 0, 1, 2, 1, 1, 0);
    add(1, 1, 'b1111, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 'b1111, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 'b1111, 0, 0, 0, 0, 0, 0, 0);
    src_en = '1;
    holdoff_cycles = HW'(2);
    foreach (vecs[i]) begin
      rst = 1'(vecs[i].r);
      global_en = 1'(vecs[i].ge);
      src_trig = NS'(vecs[i].trig);
      readout_busy = 1'(vecs[i].busy);
      step();
      chk($sformatf("vec%0d.start", i), 32'(readout_start), vecs[i].st);
      chk($sformatf("vec%0d.gid", i), 32'(grant_id), vecs[i].gid);
      chk($sformatf("vec%0d.acc", i), 32'(accepted_count), vecs[i].acc);
      chk($sformatf("vec%0d.drop", i), 32'(dropped_count), vecs[i].drop);
      chk($sformatf("vec%0d.err", i), 32'(err_no_busy), vecs[i].err);
      chk($sformatf("vec%0d.sbusy", i), 32'(sched_busy), vecs[i].sb);
    end
    init_seq();
    exp_gid = '{0, 1, 3};
    src_trig = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      wait_start(20, n);
      chk($sformatf("rr%0d.start", i), 32'(readout_start), 1);
      chk($sformatf("rr%0d.gid", i), 32'(grant_id), exp_gid[i]);
      if (i == 0) chk("rr.latency", 32'(n), 2);
      else chk($sformatf("rr%0d.spacing", i), 32'(gap + n), 5);
      readout_busy = 1'b1;
      repeat (3) step();
      readout_busy = 1'b0;
      gap = 3;
    end
    repeat (3) step();
    chk("rr.acc", 32'(accepted_count), 3);
    chk("rr.drop", 32'(dropped_count), 0);
    chk("rr.sbusy", 32'(sched_busy), 0);
    init_seq();
    holdoff_cycles = HW'(5);
    src_trig = 4'b0100;
    wait_start(20, n);
    chk("hold.start", 32'(readout_start), 1);
    chk("hold.gid", 32'(grant_id), 2);
    chk("hold.acc", 32'(accepted_count), 1);
    first = -1;
    c = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (readout_start) begin
        c++;
        if (first < 0) first = k;
      end
      readout_busy = k >= 3 && k <= 12;
      src_trig = (k >= 4 && k < 6) ? 4'b0000 : 4'b0100;
    end
    chk("hold.next_start_cycle", 32'(first), 20);
    chk("hold.start_count", 32'(c), 1);
    chk("hold.acc2", 32'(accepted_count), 2);
    chk("hold.err", 32'(err_no_busy), 0);
    init_seq();
    src_trig = 4'b0100;
    wait_start(20, n);
    readout_busy = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      src_trig = 4'b0110;
      step();
      src_trig = 4'b0100;
      step();
      if (i == 1) chk("sat.one_drop", 32'(dropped_count), 1);
    end
    chk("sat.drop", 32'(dropped_count), 15);
    src_trig = 4'b0110;
    step();
    chk("sat.hold", 32'(dropped_count), 15);
    readout_busy = 1'b0;
    wait_start(20, n);
    chk("sat.start", 32'(readout_start), 1);
    chk("sat.gid", 32'(grant_id), 1);
    init_seq();
    src_trig = 4'b0100;
    wait_start(20, n);
    readout_busy = 1'b1;
    step();
    src_trig = 4'b0101;
    step();
    src_en = 4'b1110;
    step();
    src_en = 4'b1111;
    readout_busy = 1'b0;
    count_starts(15, c);
    chk("srcen.no_start", 32'(c), 0);
    chk("srcen.drop", 32'(dropped_count), 0);
    src_trig = 4'b0001;
    step();
    src_trig = 4'b0101;
    wait_start(20, n);
    chk("gen.start", 32'(readout_start), 1);
    readout_busy = 1'b1;
    step();
    src_trig = 4'b1101;
    step();
    global_en = 1'b0;
    step();
    global_en = 1'b1;
    readout_busy = 1'b0;
    count_starts(15, c);
    chk("gen.no_start", 32'(c), 0);
    chk("gen.acc", 32'(accepted_count), 2);
    init_seq();
    holdoff_cycles = HW'(10);
    src_trig = 4'b0100;
    wait_start(20, n);
    readout_busy = 1'b1;
    repeat (2) step();
    readout_busy = 1'b0;
    repeat (2) step();
    chk("rsthold.in_holdoff", 32'(sched_busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rsthold.sbusy", 32'(sched_busy), 0);
    chk("rsthold.acc", 32'(accepted_count), 0);
    chk("rsthold.drop", 32'(dropped_count), 0);
    chk("rsthold.start", 32'(readout_start), 0);
    chk("rsthold.gid", 32'(grant_id), 0);
    chk("rsthold.err", 32'(err_no_busy), 0);
    count_starts(5, c);
    chk("rsthold.no_start", 32'(c), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trig_scheduler.md
TRIG_SCHEDULER -- requirements
Module: trig_scheduler

Interface
REQ-001 Parameter NUM_SRC, default 4, number of trigger requesters (min 2).
REQ-002 Parameter CNT_WIDTH, default 16, width of accepted/dropped counters.
REQ-003 Parameter HOLDOFF_WIDTH, default 16, width of holdoff configuration.
REQ-004 Parameter BUSY_TIMEOUT, default 8, cycles allowed for readout_busy to rise after a start.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 global_en  in  1  1 = scheduler may grant triggers.
REQ-008 src_trig  in  NUM_SRC  per-source trigger levels, rising-edge detected; bit i = source i.
REQ-009 src_en  in  NUM_SRC  per-source enable mask.
REQ-010 holdoff_cycles  in  HOLDOFF_WIDTH  dead time after readout completion.
REQ-011 readout_busy  in  1  high while the readout block is clocking out data.
REQ-012 readout_start  out  1  one-cycle start pulse to the readout block.
REQ-013 grant_id  out  $clog2(NUM_SRC)  index of the source behind the most recent start.
REQ-014 accepted_count  out  CNT_WIDTH  starts issued since reset.
REQ-015 dropped_count  out  CNT_WIDTH  edges lost to a full pending slot.
REQ-016 err_no_busy  out  1  sticky: readout_busy never rose within BUSY_TIMEOUT.
REQ-017 sched_busy  out  1  high in every state except IDLE.

Function
REQ-018 Each src_trig bit is registered once; edge_i = src_trig[i] & ~prev[i].
REQ-019 Edge on a source with src_en=0 or global_en=0 is ignored and not counted.
REQ-020 Enabled edge sets pending[i]; if pending[i] is already set and not being cleared this cycle, dropped_count increments instead.
REQ-021 Edge arriving in the same cycle as pending[i] is cleared by a grant re-sets pending[i] with no drop.
REQ-022 dropped_count saturates at all-ones; accepted_count wraps modulo 2^CNT_WIDTH.
REQ-023 States: IDLE, WAIT_BUSY, BUSY, HOLDOFF.
REQ-024 IDLE, global_en=1, any pending: round-robin grant, search from (last grant_id + 1) mod NUM_SRC upward; after reset search starts at 0.
REQ-025 Grant cycle N: readout_start=1 and grant_id updated at cycle N+1 (registered), pending[granted] cleared, accepted_count +1, next state WAIT_BUSY.
REQ-026 readout_start is high exactly one cycle per grant, never in any other cycle.
REQ-027 WAIT_BUSY: readout_busy=1 -> BUSY; BUSY_TIMEOUT cycles with readout_busy=0 -> set err_no_busy, go HOLDOFF.
REQ-028 BUSY: readout_busy=0 -> HOLDOFF loaded with holdoff_cycles; if holdoff_cycles=0 go directly to IDLE.
REQ-029 HOLDOFF: down-count each cycle; reaching 0 -> IDLE; holdoff_cycles sampled only on entry.
REQ-030 Minimum spacing between consecutive readout_start pulses = readout duration + holdoff_cycles + 2 cycles.
REQ-031 global_en falling: all pending bits cleared the next cycle; an in-progress sequence runs to IDLE; no new grant while global_en=0.
REQ-032 src_en bit cleared while pending: that pending bit cleared the next cycle, no drop count.
REQ-033 Edges during WAIT_BUSY/BUSY/HOLDOFF are queued (one deep per source) and served on return to IDLE.

Reset
REQ-034 rst=1 at a clock edge: state IDLE, pending=0, edge registers loaded with current src_trig (no spurious edge after reset), counters 0, grant_id=0, readout_start=0, err_no_busy=0, holdoff counter 0.
REQ-035 rst mid-sequence aborts immediately to the reset values of REQ-034; rst overrides all other inputs.

Verification
REQ-036 Single edge on src 2, holdoff=5, busy high cycles 3-12 after start -> one start, grant_id=2, accepted=1, next grant no earlier than 6 cycles after busy falls.
REQ-037 Simultaneous edges on src 0,1,3 in IDLE -> starts granted 0, 1, 3 in order across three sequences; accepted=3, dropped=0.
REQ-038 Two edges on src 1 during one BUSY -> one queued, dropped=1; after 2^CNT_WIDTH overflows dropped stays all-ones.
REQ-039 readout_busy held 0 after start, BUSY_TIMEOUT=8 -> err_no_busy=1 on 9th cycle, HOLDOFF entered, err stays set until rst.
REQ-040 global_en low with pending src 3 -> pending cleared, no start; src_trig held high through rst release -> no start.
REQ-041 rst asserted during HOLDOFF -> next cycle IDLE, all counters 0, readout_start=0.
